// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Package    : loader_pkg
// Description: Shared definitions for the boot-time program loader:
//              loader state enumeration and instruction word width.
// Revision   : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Instruction memory word width.
    localparam int c_WORD_W = 16;

    // Loader states, in image byte order.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module     : program_loader
// Description: Boot-time loader. Receives a program image as a byte stream
//              (LEN_HI, LEN_LO, N x {WORD_HI, WORD_LO}, CSUM), writes the N
//              words to instruction memory addresses 0..N-1, verifies the
//              8-bit modular checksum and releases the CPU only on success.
// Ports      :
//   clock          - single clock, rising edge
//   reset          - synchronous, active-low
//   start          - one-cycle load request (honoured in IDLE/DONE/ERROR)
//   in_data/valid  - incoming byte stream
//   in_ready       - byte accepted this cycle when in_valid is also high
//   mem_we/addr/wdata - registered instruction memory write port
//   cpu_reset      - active-high CPU reset, low only in DONE
//   busy/done/error - load status
//   words_written  - words written in the current or last load
// Revision   : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [c_WORD_W-1:0] mem_wdata,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_written
);

    // Largest legal word count: the full address space.
    localparam logic [31:0] c_MAX_WORDS = 32'(1) << ADDR_W;

    state_t                r_state;
    state_t                w_next;

    logic [15:0]           r_len;
    logic [7:0]            r_hi;
    logic [7:0]            r_csum;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [c_WORD_W-1:0]   r_mem_wdata;
    logic [ADDR_W:0]       r_words;

    logic                  w_accept;
    logic                  w_start_ok;
    logic [15:0]           w_len_new;
    logic                  w_oversize;
    logic                  w_last_word;
    logic                  w_receiving;

    assign w_accept    = in_valid & w_receiving;
    assign w_start_ok  = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) |
                                  (r_state == ST_ERROR));
    // Word count as it becomes complete while LEN_LO is on the bus.
    assign w_len_new   = {r_len[15:8], in_data};
    assign w_oversize  = {16'd0, w_len_new} > c_MAX_WORDS;
    // Uses the count before this word's increment, hence the +1.
    assign w_last_word = (32'(r_words) + 32'd1) == {16'd0, r_len};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) w_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_accept) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_accept) begin
                    if (w_oversize)             w_next = ST_ERROR;
                    else if (w_len_new == 16'd0) w_next = ST_CHECK;
                    else                        w_next = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (w_accept) w_next = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (w_accept) w_next = w_last_word ? ST_CHECK : ST_DATA_HI;
            end
            ST_CHECK: begin
                if (w_accept) w_next = (in_data == r_csum) ? ST_DONE : ST_ERROR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_receiving = 1'b0;
        case (r_state)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: w_receiving = 1'b1;
            default: w_receiving = 1'b0;
        endcase
    end

    assign in_ready  = w_receiving;
    assign busy      = w_receiving;
    assign cpu_reset = (r_state != ST_DONE);
    assign done      = (r_state == ST_DONE);
    assign error     = (r_state == ST_ERROR);

    // ------------------------------------------------------------------
    // Byte assembler, checksum accumulator and write port
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_len       <= '0;
            r_hi        <= '0;
            r_csum      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_words     <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_ok) begin
                r_csum  <= '0;
                r_words <= '0;
            end
            if (w_accept) begin
                case (r_state)
                    ST_LEN_HI: begin
                        r_len[15:8] <= in_data;
                        r_csum      <= r_csum + in_data;
                    end
                    ST_LEN_LO: begin
                        r_len[7:0]  <= in_data;
                        r_csum      <= r_csum + in_data;
                    end
                    ST_DATA_HI: begin
                        r_hi        <= in_data;
                        r_csum      <= r_csum + in_data;
                    end
                    ST_DATA_LO: begin
                        r_csum      <= r_csum + in_data;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_words[ADDR_W-1:0];
                        r_mem_wdata <= {r_hi, in_data};
                        r_words     <= r_words + (ADDR_W+1)'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign words_written = r_words;

endmodule : program_loader
`default_nettype wire
